// File: rtl/instruction_expander.sv
// Expands one decoded instruction plus an iteration count into a sequence of
// instruction-queue writes, each carrying up to 2^LOG_SUPERSCALAR_WIDTH copies.
module instruction_expander #(
    parameter int unsigned LOG_SUPERSCALAR_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH            = 18,
    parameter int unsigned ITER_WIDTH            = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     in_instr_type,
    input  logic [0:13]                    in_arith_instr,
    input  logic [0:8]                     in_ram_instr,
    input  logic [0:9]                     in_ld_st_instr,
    input  logic [ITER_WIDTH-1:0]          in_iter_count,
    input  logic [ADDR_WIDTH-1:0]          in_cache_addr,
    input  logic [ADDR_WIDTH-1:0]          in_main_mem_addr,
    input  logic [ADDR_WIDTH-1:0]          in_d_cache_addr,
    input  logic [ADDR_WIDTH-1:0]          in_d_main_mem_addr,
    input  logic                           q_full,
    output logic                           q_we,
    output logic [1:0]                     q_instr_type,
    output logic [LOG_SUPERSCALAR_WIDTH:0] q_copy_count,
    output logic [ADDR_WIDTH-1:0]          q_cache_addr,
    output logic [ADDR_WIDTH-1:0]          q_main_mem_addr,
    output logic [ADDR_WIDTH-1:0]          q_d_cache_addr,
    output logic [ADDR_WIDTH-1:0]          q_d_main_mem_addr,
    output logic [0:13]                    q_arith_instr,
    output logic [0:8]                     q_ram_instr,
    output logic [0:9]                     q_ld_st_instr,
    output logic                           busy
);

    localparam int unsigned SW = 1 << LOG_SUPERSCALAR_WIDTH;
    localparam int unsigned CW = LOG_SUPERSCALAR_WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                  state;
    logic [1:0]              type_q;
    logic [0:13]             arith_q;
    logic [0:8]              ram_q;
    logic [0:9]              ld_st_q;
    logic [ADDR_WIDTH-1:0]   d_cache_q;
    logic [ADDR_WIDTH-1:0]   d_main_q;
    logic [ADDR_WIDTH-1:0]   cur_cache;
    logic [ADDR_WIDTH-1:0]   cur_main;
    logic [ITER_WIDTH-1:0]   remaining;

    logic [ITER_WIDTH-1:0]   chunk;
    logic                    last_chunk;
    logic [CW-1:0]           copy_count;
    logic                    write_fire;

    // Chunk sizing: every chunk is full except possibly the last one.
    always_comb begin
        chunk      = remaining;
        last_chunk = 1'b1;
        copy_count = '0;
        if (remaining > ITER_WIDTH'(SW)) begin
            chunk      = ITER_WIDTH'(SW);
            last_chunk = 1'b0;
        end
        if (remaining != '0) begin
            copy_count = CW'(chunk - ITER_WIDTH'(1));
        end
    end

    assign write_fire = (state == EMIT) && !q_full;

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            type_q    <= '0;
            arith_q   <= '0;
            ram_q     <= '0;
            ld_st_q   <= '0;
            d_cache_q <= '0;
            d_main_q  <= '0;
            cur_cache <= '0;
            cur_main  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        type_q    <= in_instr_type;
                        arith_q   <= in_arith_instr;
                        ram_q     <= in_ram_instr;
                        ld_st_q   <= in_ld_st_instr;
                        d_cache_q <= in_d_cache_addr;
                        d_main_q  <= in_d_main_mem_addr;
                        cur_cache <= in_cache_addr;
                        cur_main  <= in_main_mem_addr;
                        remaining <= in_iter_count;
                        // A zero-length loop is dropped without issuing anything.
                        state     <= (in_iter_count == '0) ? IDLE : EMIT;
                    end
                end
                EMIT: begin
                    if (write_fire) begin
                        remaining <= remaining - chunk;
                        cur_cache <= cur_cache + (d_cache_q << LOG_SUPERSCALAR_WIDTH);
                        cur_main  <= cur_main + (d_main_q << LOG_SUPERSCALAR_WIDTH);
                        if (last_chunk) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready          = (state == IDLE);
    assign busy              = (state == EMIT);
    assign q_we              = write_fire;
    assign q_instr_type      = type_q;
    assign q_copy_count      = copy_count;
    assign q_cache_addr      = cur_cache;
    assign q_main_mem_addr   = cur_main;
    assign q_d_cache_addr    = d_cache_q;
    assign q_d_main_mem_addr = d_main_q;
    assign q_arith_instr     = arith_q;
    assign q_ram_instr       = ram_q;
    assign q_ld_st_instr     = ld_st_q;

endmodule

// File: tb/tb_instruction_expander.sv
// Directed and randomized checks of instruction_expander against a chunk-list
// model computed directly from iteration count, bases and strides.
module tb_instruction_expander;

    localparam int LOG = 3;
    localparam int AW  = 18;
    localparam int IW  = 16;
    localparam int SW  = 1 << LOG;
    localparam logic [63:0] AMASK = 64'h3FFFF;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_instr_type;
    logic [0:13]   in_arith_instr;
    logic [0:8]    in_ram_instr;
    logic [0:9]    in_ld_st_instr;
    logic [IW-1:0] in_iter_count;
    logic [AW-1:0] in_cache_addr;
    logic [AW-1:0] in_main_mem_addr;
    logic [AW-1:0] in_d_cache_addr;
    logic [AW-1:0] in_d_main_mem_addr;
    logic          q_full;
    logic          q_we;
    logic [1:0]    q_instr_type;
    logic [LOG:0]  q_copy_count;
    logic [AW-1:0] q_cache_addr;
    logic [AW-1:0] q_main_mem_addr;
    logic [AW-1:0] q_d_cache_addr;
    logic [AW-1:0] q_d_main_mem_addr;
    logic [0:13]   q_arith_instr;
    logic [0:8]    q_ram_instr;
    logic [0:9]    q_ld_st_instr;
    logic          busy;

    int tests = 0;
    int fails = 0;

    instruction_expander #(
        .LOG_SUPERSCALAR_WIDTH(LOG),
        .ADDR_WIDTH(AW),
        .ITER_WIDTH(IW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr_type(in_instr_type),
        .in_arith_instr(in_arith_instr),
        .in_ram_instr(in_ram_instr),
        .in_ld_st_instr(in_ld_st_instr),
        .in_iter_count(in_iter_count),
        .in_cache_addr(in_cache_addr),
        .in_main_mem_addr(in_main_mem_addr),
        .in_d_cache_addr(in_d_cache_addr),
        .in_d_main_mem_addr(in_d_main_mem_addr),
        .q_full(q_full),
        .q_we(q_we),
        .q_instr_type(q_instr_type),
        .q_copy_count(q_copy_count),
        .q_cache_addr(q_cache_addr),
        .q_main_mem_addr(q_main_mem_addr),
        .q_d_cache_addr(q_d_cache_addr),
        .q_d_main_mem_addr(q_d_main_mem_addr),
        .q_arith_instr(q_arith_instr),
        .q_ram_instr(q_ram_instr),
        .q_ld_st_instr(q_ld_st_instr),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_we"},    64'(q_we), 64'(0));
        chk({tag, "_busy"},  64'(busy), 64'(0));
        chk({tag, "_ready"}, 64'(in_ready), 64'(1));
        chk({tag, "_cc"},    64'(q_copy_count), 64'(0));
        chk({tag, "_ca"},    64'(q_cache_addr), 64'(0));
        chk({tag, "_ma"},    64'(q_main_mem_addr), 64'(0));
        chk({tag, "_dca"},   64'(q_d_cache_addr), 64'(0));
        chk({tag, "_dma"},   64'(q_d_main_mem_addr), 64'(0));
        chk({tag, "_type"},  64'(q_instr_type), 64'(0));
        chk({tag, "_words"}, 64'({q_arith_instr, q_ram_instr, q_ld_st_instr}), 64'(0));
    endtask

    // Entered and left at negedge+1. Model: chunk k has copies min(iter-k*SW, SW)
    // and base addresses base + k*SW*stride modulo 2^AW.
    task automatic send(input logic [1:0] ty, input logic [13:0] ar, input logic [8:0] rm,
                        input logic [9:0] ls, input int iter,
                        input logic [AW-1:0] cb, input logic [AW-1:0] mb,
                        input logic [AW-1:0] dc, input logic [AW-1:0] dm,
                        input int stall_after, input int stall_len,
                        input bit rnd_stall, input int abort_after);
        int n, idx, cyc, stalled, left;
        bit full;
        logic [63:0] e_cc, e_ca, e_ma;
        n = (iter + SW - 1) / SW;
        chk("ready_before_accept", 64'(in_ready), 64'(1));
        in_valid           = 1'b1;
        in_instr_type      = ty;
        in_arith_instr     = ar;
        in_ram_instr       = rm;
        in_ld_st_instr     = ls;
        in_iter_count      = IW'(iter);
        in_cache_addr      = cb;
        in_main_mem_addr   = mb;
        in_d_cache_addr    = dc;
        in_d_main_mem_addr = dm;
        q_full             = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid           = 1'b0;
        in_arith_instr     = ~ar;
        in_cache_addr      = ~cb;
        in_d_cache_addr    = ~dc;
        in_iter_count      = 16'hFFFF;
        if (n == 0) begin
            #1;
            chk("zero_we", 64'(q_we), 64'(0));
            chk("zero_busy", 64'(busy), 64'(0));
            chk("zero_ready", 64'(in_ready), 64'(1));
            return;
        end
        idx = 0;
        cyc = 0;
        stalled = 0;
        while (idx < n && cyc < 300) begin
            if (abort_after >= 0 && idx == abort_after) break;
            if (rnd_stall) full = ($urandom_range(0, 2) == 0);
            else full = (stall_after >= 0 && idx == stall_after && stalled < stall_len);
            if (full) stalled++;
            q_full = full;
            #1;
            left = iter - idx * SW;
            e_cc = 64'(((left < SW) ? left : SW) - 1);
            e_ca = (64'(cb) + 64'(idx) * 64'(SW) * 64'(dc)) & AMASK;
            e_ma = (64'(mb) + 64'(idx) * 64'(SW) * 64'(dm)) & AMASK;
            chk("emit_busy", 64'(busy), 64'(1));
            chk("emit_ready", 64'(in_ready), 64'(0));
            chk("emit_we", 64'(q_we), 64'(!full));
            chk("copy_count", 64'(q_copy_count), e_cc);
            chk("cache_addr", 64'(q_cache_addr), e_ca);
            chk("main_addr", 64'(q_main_mem_addr), e_ma);
            chk("d_cache", 64'(q_d_cache_addr), 64'(dc));
            chk("d_main", 64'(q_d_main_mem_addr), 64'(dm));
            chk("type", 64'(q_instr_type), 64'(ty));
            chk("arith", 64'(q_arith_instr), 64'(ar));
            chk("ram", 64'(q_ram_instr), 64'(rm));
            chk("ld_st", 64'(q_ld_st_instr), 64'(ls));
            if (!full) idx++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) chk("emit_timeout", 64'(idx), 64'(n));
        if (abort_after >= 0 && idx == abort_after) begin
            q_full = 1'b1;
            reset  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            reset  = 1'b0;
            q_full = 1'b0;
            #1;
            chk_idle_zero("abort");
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                #1;
                chk("abort_no_we", 64'(q_we), 64'(0));
                chk("abort_ready", 64'(in_ready), 64'(1));
            end
            return;
        end
        q_full = 1'b0;
        #1;
        chk("done_busy", 64'(busy), 64'(0));
        chk("done_ready", 64'(in_ready), 64'(1));
        chk("done_we", 64'(q_we), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        in_valid           = 1'b0;
        in_instr_type      = '0;
        in_arith_instr     = '0;
        in_ram_instr       = '0;
        in_ld_st_instr     = '0;
        in_iter_count      = '0;
        in_cache_addr      = '0;
        in_main_mem_addr   = '0;
        in_d_cache_addr    = '0;
        in_d_main_mem_addr = '0;
        q_full             = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_idle_zero("reset");

        // Basic single chunk of two copies.
        send(2'd1, 14'd20, 9'd0, 10'd0, 2, 18'd0, 18'd0, 18'd0, 18'd0, -1, 0, 1'b0, -1);
        // Multi-chunk: 8+8+4 copies.
        send(2'd2, 14'h1234, 9'h0AB, 10'h155, 20, 18'd100, 18'd1000, 18'd2, 18'd4, -1, 0, 1'b0, -1);
        // Backpressure after the first write.
        send(2'd2, 14'h0F0F, 9'h111, 10'h2AA, 20, 18'd100, 18'd1000, 18'd2, 18'd4, 1, 3, 1'b0, -1);
        // Zero count dropped, next instruction accepted the following cycle.
        send(2'd3, 14'd7, 9'd7, 10'd7, 0, 18'd5, 18'd5, 18'd1, 18'd1, -1, 0, 1'b0, -1);
        send(2'd0, 14'd9, 9'd3, 10'd1, 8, 18'd5, 18'd6, 18'd1, 18'd1, -1, 0, 1'b0, -1);
        // Address wrap modulo 2^18.
        send(2'd1, 14'd1, 9'd2, 10'd3, 16, 18'h3FFF8, 18'h3FFFC, 18'd1, 18'h20000, -1, 0, 1'b0, -1);
        // Reset in the middle of a 5-chunk loop, then a single-copy instruction.
        send(2'd1, 14'd5, 9'd5, 10'd5, 40, 18'd64, 18'd128, 18'd3, 18'd5, -1, 0, 1'b0, 2);
        send(2'd2, 14'd33, 9'd44, 10'd55, 1, 18'd77, 18'd88, 18'd9, 18'd9, -1, 0, 1'b0, -1);

        // Randomized instructions with random backpressure.
        for (int t = 0; t < 12; t++) begin
            send(2'($urandom), 14'($urandom), 9'($urandom), 10'($urandom),
                 int'($urandom_range(0, 40)),
                 18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
                 -1, 0, 1'b1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
